// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light request path: debounce
// state encoding, default tuning parameters and the seven-segment glyph table.
package traffic_pkg;

  typedef enum logic [1:0] {
    DEB_LOW      = 2'd0,
    DEB_RISE_CHK = 2'd1,
    DEB_HIGH     = 2'd2,
    DEB_FALL_CHK = 2'd3
  } deb_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int MAX_QUEUE_DEF       = 9;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex value 0..F.
  localparam logic [0:15][6:0] SEG_GLYPH = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_decoder.sv
// Purely combinational hex digit to active-low seven-segment decode.
module seg7_decoder
  import traffic_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[hex];

endmodule

// File: rtl/vehicle_request_sensor.sv
// Road-loop vehicle detector: synchronizes and debounces the loop level,
// counts arrivals against grants and raises car while anyone is waiting.
module vehicle_request_sensor
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int MAX_QUEUE       = MAX_QUEUE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_raw,
  input  logic       grant,
  output logic       car,
  output logic [3:0] queue_cnt,
  output logic [6:0] seg0
);

  localparam logic [3:0] DEB_LIM = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] Q_MAX   = 4'(MAX_QUEUE);

  logic [1:0] sync_pipe;
  logic       sensor_sync;
  deb_state_t state;
  logic [3:0] stab_cnt;
  logic       arrival;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], sensor_raw};
  end

  assign sensor_sync = sync_pipe[1];

  // An arrival is the qualifying edge out of RISE_CHK; the count updates on
  // that same edge. With DEBOUNCE_CYCLES=1 this still takes one pass through
  // RISE_CHK so the latency stays DEBOUNCE_CYCLES+2 from the first raw sample.
  assign arrival = (state == DEB_RISE_CHK) && sensor_sync && (stab_cnt == DEB_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= DEB_LOW;
      stab_cnt <= '0;
    end else begin
      case (state)
        DEB_LOW: if (sensor_sync) begin
          state    <= DEB_RISE_CHK;
          stab_cnt <= 4'd1;
        end
        DEB_RISE_CHK: begin
          if (!sensor_sync) begin
            state    <= DEB_LOW;
            stab_cnt <= '0;
          end else if (stab_cnt == DEB_LIM) begin
            state    <= DEB_HIGH;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + 4'd1;
          end
        end
        DEB_HIGH: if (!sensor_sync) begin
          state    <= DEB_FALL_CHK;
          stab_cnt <= 4'd1;
        end
        DEB_FALL_CHK: begin
          if (sensor_sync) begin
            state    <= DEB_HIGH;
            stab_cnt <= '0;
          end else if (stab_cnt == DEB_LIM) begin
            state    <= DEB_LOW;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + 4'd1;
          end
        end
        default: begin
          state    <= DEB_LOW;
          stab_cnt <= '0;
        end
      endcase
    end
  end

  // Simultaneous arrival and grant cancel out, even at the saturation limits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      queue_cnt <= '0;
    end else if (arrival && !grant) begin
      if (queue_cnt != Q_MAX) queue_cnt <= queue_cnt + 4'd1;
    end else if (grant && !arrival) begin
      if (queue_cnt != 4'd0) queue_cnt <= queue_cnt - 4'd1;
    end
  end

  assign car = (queue_cnt != 4'd0);

  seg7_decoder u_seg7 (
    .hex (queue_cnt),
    .seg (seg0)
  );

endmodule
